// File: rtl/ahb_pkg.sv
// Shared AHB-lite definitions: transfer encodings, arbiter states and the
// fixed master indices used by the CPU-side bus wrappers.
package ahb_pkg;

  localparam int AHB_TRANS_BITS = 2;
  localparam int AHB_SIZE_BITS  = 3;

  localparam logic [AHB_TRANS_BITS-1:0] AHB_TRANS_IDLE   = 2'b00;
  localparam logic [AHB_TRANS_BITS-1:0] AHB_TRANS_BUSY   = 2'b01;
  localparam logic [AHB_TRANS_BITS-1:0] AHB_TRANS_NONSEQ = 2'b10;
  localparam logic [AHB_TRANS_BITS-1:0] AHB_TRANS_SEQ    = 2'b11;

  localparam int MASTER_IM = 0;
  localparam int MASTER_DM = 1;

  typedef enum logic {
    OWN    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/ahb_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first set request found
// scanning ptr+1, ptr+2, ... with wrap, the pointer itself checked last.
module rr_pick #(
  parameter int N  = 2,
  parameter int MW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [MW-1:0] ptr,
  output logic [MW-1:0] idx,
  output logic          valid
);

  logic [MW-1:0] cand;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = MW'((int'(ptr) + i) % N);
      if (!valid && req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB-lite bus arbiter: one-hot registered grant, address/data-phase owner
// tracking, round-robin with a beat limit, and locked-sequence support.
module ahb_bus_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_BEATS      = 4,
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_MASTERS-1:0]    hreq,
  input  logic [NUM_MASTERS-1:0]    hlock,
  input  logic [AHB_TRANS_BITS-1:0] htrans,
  input  logic                      hready,
  output logic [NUM_MASTERS-1:0]    hgrant,
  output logic [MW-1:0]             hmaster,
  output logic [MW-1:0]             hmaster_dp,
  output logic                      hmastlock
);

  localparam int            CW        = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [CW-1:0] BEAT_LAST = CW'(MAX_BEATS - 1);
  localparam logic [MW-1:0] DEF_IDX   = MW'(DEFAULT_MASTER);

  arb_state_e             state, state_nxt;
  logic [MW-1:0]          rr_ptr, hmaster_nxt;
  logic [NUM_MASTERS-1:0] hgrant_nxt, others;
  logic [CW-1:0]          beat_cnt, beat_cnt_nxt;
  logic                   mastlock_nxt, rearb;
  logic                   accepted, nonseq, idle_beat;
  logic                   owner_req, owner_lock, others_req, at_limit;
  logic [MW-1:0]          pick_idx;
  logic                   pick_vld;

  // The owner is masked out so the scan only ever finds a competing master.
  assign others     = hreq & ~hgrant;
  assign others_req = |others;
  assign owner_req  = hreq[hmaster];
  assign owner_lock = hlock[hmaster];
  assign accepted   = hready && htrans[1];
  assign nonseq     = hready && (htrans == AHB_TRANS_NONSEQ);
  assign idle_beat  = hready && (htrans == AHB_TRANS_IDLE);
  assign at_limit   = accepted && (beat_cnt == BEAT_LAST);

  rr_pick #(
    .N  (NUM_MASTERS),
    .MW (MW)
  ) u_rr_pick (
    .req   (others),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  always_comb begin
    state_nxt    = state;
    mastlock_nxt = hmastlock;
    hmaster_nxt  = hmaster;
    rearb        = 1'b0;
    if (hready) begin
      case (state)
        OWN: begin
          if (nonseq && owner_lock) begin
            state_nxt    = LOCKED;
            mastlock_nxt = 1'b1;
          end else begin
            rearb = 1'b1;
          end
        end
        LOCKED: begin
          if (!owner_lock) begin
            state_nxt    = OWN;
            mastlock_nxt = 1'b0;
            rearb        = 1'b1;
          end
        end
        default: begin
          state_nxt    = OWN;
          mastlock_nxt = 1'b0;
        end
      endcase
      // A release with a waiting master hands over on the same edge, no idle gap.
      if (rearb && (!owner_req || (at_limit && others_req))) begin
        if (pick_vld) begin
          hmaster_nxt = pick_idx;
        end else if (!owner_req) begin
          hmaster_nxt = DEF_IDX;
        end
      end
    end

    hgrant_nxt              = '0;
    hgrant_nxt[hmaster_nxt] = 1'b1;

    if (hmaster_nxt != hmaster || idle_beat) begin
      beat_cnt_nxt = '0;
    end else if (accepted && beat_cnt != BEAT_LAST) begin
      beat_cnt_nxt = beat_cnt + 1'b1;
    end else begin
      beat_cnt_nxt = beat_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= OWN;
      hmaster    <= DEF_IDX;
      hmaster_dp <= DEF_IDX;
      hgrant     <= NUM_MASTERS'(1) << DEFAULT_MASTER;
      hmastlock  <= 1'b0;
      rr_ptr     <= DEF_IDX;
      beat_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      hmaster   <= hmaster_nxt;
      hgrant    <= hgrant_nxt;
      hmastlock <= mastlock_nxt;
      beat_cnt  <= beat_cnt_nxt;
      if (hmaster_nxt != hmaster) begin
        rr_ptr <= hmaster_nxt;
      end
      if (hready) begin
        hmaster_dp <= hmaster;
      end
    end
  end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed bench for ahb_bus_arbiter (2 masters, default 0, 4-beat limit):
// a vector table for per-cycle behaviour plus a reset-during-lock sequence.
module tb_ahb_bus_arbiter;
  import ahb_pkg::*;

  localparam int NM = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NM-1:0] hreq, hlock;
  logic [1:0]    htrans;
  logic          hready;
  logic [NM-1:0] hgrant;
  logic [0:0]    hmaster, hmaster_dp;
  logic          hmastlock;

  always #5 clk = ~clk;

  ahb_bus_arbiter #(
    .NUM_MASTERS    (NM),
    .DEFAULT_MASTER (0),
    .MAX_BEATS      (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hreq       (hreq),
    .hlock      (hlock),
    .htrans     (htrans),
    .hready     (hready),
    .hgrant     (hgrant),
    .hmaster    (hmaster),
    .hmaster_dp (hmaster_dp),
    .hmastlock  (hmastlock)
  );

  typedef struct packed {
    logic       rst;
    logic [1:0] hreq;
    logic [1:0] hlock;
    logic [1:0] htrans;
    logic       hready;
    logic [1:0] g;
    logic       m;
    logic       d;
    logic       l;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [1:0] TI = AHB_TRANS_IDLE;
  localparam logic [1:0] TB = AHB_TRANS_BUSY;
  localparam logic [1:0] TN = AHB_TRANS_NONSEQ;
  localparam logic [1:0] TS = AHB_TRANS_SEQ;

  function automatic vec_t mk(logic r, logic [1:0] rq, logic [1:0] lk, logic [1:0] tr,
                              logic rdy, logic [1:0] g, logic m, logic d, logic l);
    vec_t v;
    v = '{rst: r, hreq: rq, hlock: lk, htrans: tr, hready: rdy, g: g, m: m, d: d, l: l};
    return v;
  endfunction

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst    = v.rst;
    hreq   = v.hreq;
    hlock  = v.hlock;
    htrans = v.htrans;
    hready = v.hready;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input vec_t v);
    logic [4:0] act, exp;
    act = {hgrant, hmaster, hmaster_dp, hmastlock};
    exp = {v.g, v.m, v.d, v.l};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got grant=%b m=%b dp=%b lock=%b, want grant=%b m=%b dp=%b lock=%b",
               name, act[4:3], act[2], act[1], act[0], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; hreq = '0; hlock = '0; htrans = TI; hready = 1'b1;

    // reset, then idle with nobody requesting
    vecs.push_back(mk(1, 2'b00, 2'b00, TI, 1, 2'b01, 0, 0, 0));
    vecs.push_back(mk(1, 2'b00, 2'b00, TI, 1, 2'b01, 0, 0, 0));
    vecs.push_back(mk(0, 2'b00, 2'b00, TI, 1, 2'b01, 0, 0, 0));
    vecs.push_back(mk(0, 2'b00, 2'b00, TI, 1, 2'b01, 0, 0, 0));
    // contention: four beats for M0, then M1; data phase lags by one
    vecs.push_back(mk(0, 2'b11, 2'b00, TN, 1, 2'b01, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 2'b00, TN, 1, 2'b01, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 2'b00, TN, 1, 2'b01, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 2'b00, TN, 1, 2'b10, 1, 0, 0));
    vecs.push_back(mk(0, 2'b11, 2'b00, TN, 1, 2'b10, 1, 1, 0));
    // wait states: M1 releases, M0 waits; switch only when hready returns
    vecs.push_back(mk(0, 2'b01, 2'b00, TN, 0, 2'b10, 1, 1, 0));
    vecs.push_back(mk(0, 2'b01, 2'b00, TN, 0, 2'b10, 1, 1, 0));
    vecs.push_back(mk(0, 2'b01, 2'b00, TN, 0, 2'b10, 1, 1, 0));
    vecs.push_back(mk(0, 2'b01, 2'b00, TI, 1, 2'b01, 0, 1, 0));
    vecs.push_back(mk(0, 2'b01, 2'b00, TI, 1, 2'b01, 0, 0, 0));
    // hand over to M1, then locked burst of ten beats with M0 waiting
    vecs.push_back(mk(0, 2'b10, 2'b00, TI, 1, 2'b10, 1, 0, 0));
    vecs.push_back(mk(0, 2'b11, 2'b10, TN, 1, 2'b10, 1, 1, 1));
    for (int i = 0; i < 9; i++)
      vecs.push_back(mk(0, 2'b11, 2'b10, TS, 1, 2'b10, 1, 1, 1));
    vecs.push_back(mk(0, 2'b11, 2'b00, TS, 0, 2'b10, 1, 1, 1));
    vecs.push_back(mk(0, 2'b11, 2'b00, TS, 1, 2'b01, 0, 1, 0));
    vecs.push_back(mk(0, 2'b00, 2'b00, TI, 1, 2'b01, 0, 0, 0));
    // release to default master
    vecs.push_back(mk(0, 2'b10, 2'b00, TI, 1, 2'b10, 1, 0, 0));
    vecs.push_back(mk(0, 2'b10, 2'b00, TN, 1, 2'b10, 1, 1, 0));
    vecs.push_back(mk(0, 2'b00, 2'b00, TI, 1, 2'b01, 0, 1, 0));
    vecs.push_back(mk(0, 2'b00, 2'b00, TI, 1, 2'b01, 0, 0, 0));
    // IDLE clears the beat count, BUSY neither counts nor clears
    vecs.push_back(mk(0, 2'b11, 2'b00, TN, 1, 2'b01, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 2'b00, TS, 1, 2'b01, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 2'b00, TS, 1, 2'b01, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 2'b00, TI, 1, 2'b01, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 2'b00, TN, 1, 2'b01, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 2'b00, TB, 1, 2'b01, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 2'b00, TS, 1, 2'b01, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 2'b00, TS, 1, 2'b01, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 2'b00, TS, 1, 2'b10, 1, 0, 0));

    foreach (vecs[i]) begin
      apply(vecs[i]);
      check($sformatf("vec%0d", i), vecs[i]);
    end

    // reset in the middle of a locked burst owned by M1
    v = mk(0, 2'b11, 2'b10, TN, 1, 2'b10, 1, 1, 1);
    apply(v); check("lock_enter", v);
    v = mk(0, 2'b11, 2'b10, TS, 1, 2'b10, 1, 1, 1);
    apply(v); check("lock_hold", v);
    v = mk(1, 2'b11, 2'b10, TS, 1, 2'b01, 0, 0, 0);
    apply(v); check("rst_in_lock", v);
    n_cmp++;
    if (dut.beat_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL rst_beat_cnt: got %0d, want 0", dut.beat_cnt);
    end
    // lock is gone: SEQ with hlock high must not relock, M1 regains by request
    v = mk(0, 2'b10, 2'b10, TS, 1, 2'b10, 1, 0, 0);
    apply(v); check("post_rst", v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
